// File: rtl/pwm_pkg.sv
// pwm_pkg: shared counter width, level encoding and capture FSM states
package pwm_pkg;
  localparam int CBITS_DEFAULT = 11;
  localparam int LEVEL_W = 3;
  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_e;
  function automatic int nominal_width(input logic [LEVEL_W-1:0] lvl, input int cbits = CBITS_DEFAULT);
    return (int'(lvl) << (cbits - 4)) + (1 << (cbits - 5));
  endfunction
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: multi-flop synchronizer with rise/fall detection on the synchronized line
module pwm_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic s_d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_i};
      s_d_q  <= sync_q[STAGES-1];
    end
  end
  assign s_o    = sync_q[STAGES-1];
  assign rise_o = s_o & ~s_d_q;
  assign fall_o = ~s_o & s_d_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period, decodes the level code, flags stuck lines
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CBITS       = CBITS_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic               meas_valid,
  output logic [CBITS:0]     high_time,
  output logic [CBITS:0]     period,
  output logic [LEVEL_W-1:0] level,
  output logic               code_err,
  output logic               stuck_hi,
  output logic               stuck_lo
);
  localparam int W  = CBITS + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] CMAX = '1;
  state_e state_q, state_d;
  logic [W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d, high_q, high_d, per_q, per_d, hinc, pinc;
  logic [IW-1:0] idle_q, idle_d;
  logic [LEVEL_W-1:0] level_q, level_d, lvl;
  logic err_q, err_d, valid_q, valid_d, shi_q, shi_d, slo_q, slo_d;
  logic s, rise, fall, edg, hit, err;
  int hval, nom;
  pwm_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (pwm_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );
  always_comb begin
    edg     = rise | fall;
    hit     = ~edg && idle_q == IW'(TIMEOUT - 1);
    hinc    = hcnt_q == CMAX ? hcnt_q : hcnt_q + 1'b1;
    pinc    = pcnt_q == CMAX ? pcnt_q : pcnt_q + 1'b1;
    idle_d  = edg ? '0 : idle_q == IW'(TIMEOUT) ? idle_q : idle_q + 1'b1;
    lvl     = hcnt_q[CBITS-2:CBITS-4];
    hval    = int'(hcnt_q);
    nom     = nominal_width(lvl, CBITS);
    err     = hval > nom + TOL || hval < nom - TOL;
    shi_d   = edg ? 1'b0 : hit ? s : shi_q;
    slo_d   = edg ? 1'b0 : hit ? ~s : slo_q;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    high_d  = high_q;
    per_d   = per_q;
    level_d = level_q;
    err_d   = err_q;
    valid_d = 1'b0;
    if (hit) state_d = SEEK;
    else begin
      case (state_q)
        SEEK: if (rise) begin
          state_d = HIGH;
          hcnt_d  = W'(1);
          pcnt_d  = W'(1);
        end
        HIGH: begin
          pcnt_d  = pinc;
          state_d = fall ? LOW : HIGH;
          hcnt_d  = fall ? hcnt_q : hinc;
        end
        LOW: if (rise) begin
          state_d = HIGH;
          high_d  = hcnt_q;
          per_d   = pcnt_q;
          level_d = lvl;
          err_d   = err;
          valid_d = 1'b1;
          hcnt_d  = W'(1);
          pcnt_d  = W'(1);
        end else pcnt_d = pinc;
        default: state_d = SEEK;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      high_q  <= '0;
      per_q   <= '0;
      idle_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      shi_q   <= 1'b0;
      slo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      high_q  <= high_d;
      per_q   <= per_d;
      idle_q  <= idle_d;
      level_q <= level_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
    end
  end
  assign meas_valid = valid_q;
  assign high_time  = high_q;
  assign period     = per_q;
  assign level      = level_q;
  assign code_err   = err_q;
  assign stuck_hi   = shi_q;
  assign stuck_lo   = slo_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench driving PWM waveforms and checking each measurement strobe
module tb_pwm_capture;
  localparam int CBITS   = 11;
  localparam int SYNC    = 2;
  localparam int TOL     = 8;
  localparam int TIMEOUT = 4096;
  typedef struct {int h; int p;} exp_t;
  logic clk = 1'b0;
  logic rst, pwm_in, meas_valid, code_err, stuck_hi, stuck_lo;
  logic [CBITS:0] high_time, period;
  logic [2:0] level;
  exp_t q[$];
  int compared = 0, mismatched = 0, last_h = 0, last_p = 0;
  always #5 clk = ~clk;
  pwm_capture #(.CBITS(CBITS), .SYNC_STAGES(SYNC), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .meas_valid (meas_valid),
    .high_time  (high_time),
    .period     (period),
    .level      (level),
    .code_err   (code_err),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );
  task automatic send(input int h, input int p);
    exp_t e;
    e.h = h;
    e.p = p;
    q.push_back(e);
    last_h = h;
    last_p = p;
    pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (p - h) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared += 7;
    if (meas_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0b want 0", meas_valid); end
    if (high_time !== '0) begin mismatched++; $display("FAIL reset_high got %0d want 0", high_time); end
    if (period !== '0) begin mismatched++; $display("FAIL reset_period got %0d want 0", period); end
    if (level !== '0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
    if (code_err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %0b want 0", code_err); end
    if (stuck_hi !== 1'b0) begin mismatched++; $display("FAIL reset_stuck_hi got %0b want 0", stuck_hi); end
    if (stuck_lo !== 1'b0) begin mismatched++; $display("FAIL reset_stuck_lo got %0b want 0", stuck_lo); end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask
  task automatic test_levels;
    send(64, 2048);
    send(960, 2048);
    send(100, 2048);
    send(70, 2048);
    send(1, 2048);
  endtask
  task automatic test_back_to_back;
    send(64, 2048);
    send(64, 1024);
    send(500, 1024);
  endtask
  task automatic test_stuck;
    pwm_in = 1'b1;
    repeat (SYNC + TIMEOUT) @(posedge clk);
    #1;
    compared++;
    if (stuck_hi !== 1'b0) begin mismatched++; $display("FAIL stuck_hi_early got %0b want 0", stuck_hi); end
    @(posedge clk);
    #1;
    compared += 4;
    if (stuck_hi !== 1'b1) begin mismatched++; $display("FAIL stuck_hi_set got %0b want 1", stuck_hi); end
    if (stuck_lo !== 1'b0) begin mismatched++; $display("FAIL stuck_lo_while_hi got %0b want 0", stuck_lo); end
    if (high_time !== last_h[CBITS:0]) begin mismatched++; $display("FAIL stuck_hold_high got %0d want %0d", high_time, last_h); end
    if (period !== last_p[CBITS:0]) begin mismatched++; $display("FAIL stuck_hold_period got %0d want %0d", period, last_p); end
    repeat (5000 - (SYNC + TIMEOUT + 1)) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    compared += 2;
    if (stuck_hi !== 1'b0) begin mismatched++; $display("FAIL stuck_hi_clear got %0b want 0", stuck_hi); end
    if (stuck_lo !== 1'b0) begin mismatched++; $display("FAIL stuck_lo_clear got %0b want 0", stuck_lo); end
    repeat (500) @(posedge clk);
    #1;
    send(960, 2048);
  endtask
  task automatic test_reset_mid;
    pwm_in = 1'b1;
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    compared += 5;
    if (meas_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_valid got %0b want 0", meas_valid); end
    if (high_time !== '0) begin mismatched++; $display("FAIL mid_rst_high got %0d want 0", high_time); end
    if (period !== '0) begin mismatched++; $display("FAIL mid_rst_period got %0d want 0", period); end
    if (level !== '0) begin mismatched++; $display("FAIL mid_rst_level got %0d want 0", level); end
    if (code_err !== 1'b0) begin mismatched++; $display("FAIL mid_rst_err got %0b want 0", code_err); end
    repeat (100) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    send(64, 2048);
    send(960, 2048);
  endtask
  task automatic test_drain;
    pwm_in = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin mismatched++; $display("FAIL drain_pending got %0d want 0", q.size()); end
    pwm_in = 1'b0;
    repeat (10) @(posedge clk);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && meas_valid) begin
          if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_strobe got high=%0d period=%0d want none", high_time, period);
          end else begin
            exp_t e;
            int lv, nom;
            logic er;
            e = q.pop_front();
            lv = (e.h >> (CBITS - 4)) & 7;
            nom = lv * (1 << (CBITS - 4)) + (1 << (CBITS - 5));
            er = (e.h > nom + TOL) || (e.h < nom - TOL);
            compared += 4;
            if (high_time !== e.h[CBITS:0]) begin mismatched++; $display("FAIL sb_high got %0d want %0d", high_time, e.h); end
            if (period !== e.p[CBITS:0]) begin mismatched++; $display("FAIL sb_period got %0d want %0d", period, e.p); end
            if (level !== lv[2:0]) begin mismatched++; $display("FAIL sb_level got %0d want %0d", level, lv); end
            if (code_err !== er) begin mismatched++; $display("FAIL sb_code_err got %0b want %0b (high %0d)", code_err, er, e.h); end
          end
        end
      end
    join_none
    test_reset;
    test_levels;
    test_back_to_back;
    test_stuck;
    test_reset_mid;
    test_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
